// File: rtl/prbs10_if.sv
// Word-stream bundle between an LFSR word source and prbs10_checker.
// The master drives words; the slave (checker) returns lock/error status.
interface prbs10_if #(
  parameter int unsigned ERR_W = 16
);
  logic             in_valid;
  logic [9:0]       in_word;
  logic             clear_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state;

  modport master (
    output in_valid, in_word, clear_err,
    input  locked, err_pulse, err_count, state
  );

  modport slave (
    input  in_valid, in_word, clear_err,
    output locked, err_pulse, err_count, state
  );
endinterface

// File: rtl/prbs10_checker.sv
// Self-synchronising checker for the 10-bit XNOR LFSR word stream
// (x^10+x^7+x^3+x^2+1): seeds, confirms, locks, then counts word errors.
module prbs10_checker #(
  parameter int unsigned STEP       = 11,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic     clk_i,
  input  logic     rst_i,
  prbs10_if.slave  bus
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [9:0] LOCKUP = 10'h3FF;

  state_t           state_q, state_d;
  logic [9:0]       expected_q, expected_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             err_pulse_q, err_pulse_d;

  logic [9:0]       adv_word;
  logic [9:0]       adv_expected;
  logic             word_match;
  logic [3:0]       match_inc;
  logic [3:0]       miss_inc;

  // STEP unrolled shift stages; purely combinational.
  function automatic logic [9:0] adv(input logic [9:0] x);
    logic [9:0] s;
    s = x;
    for (int unsigned i = 0; i < STEP; i++) begin
      s = {s[8:0], ~(s[9] ^ s[6] ^ s[2] ^ s[1])};
    end
    return s;
  endfunction

  assign adv_word     = adv(bus.in_word);
  assign adv_expected = adv(expected_q);
  assign word_match   = (bus.in_word == expected_q);
  assign match_inc    = match_cnt_q + 4'd1;
  assign miss_inc     = miss_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    err_count_d = bus.clear_err ? '0 : err_count_q;

    if (bus.in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.in_word != LOCKUP) begin
            expected_d  = adv_word;
            match_cnt_d = '0;
            state_d     = CONFIRM;
          end
        end
        CONFIRM: begin
          if (word_match) begin
            expected_d  = adv_expected;
            match_cnt_d = match_inc;
            if (match_inc == 4'(LOCK_CNT)) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else if (bus.in_word == LOCKUP) begin
            match_cnt_d = '0;
            state_d     = HUNT;
          end else begin
            expected_d  = adv_word;
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          expected_d = adv_expected;
          if (word_match) begin
            miss_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            miss_cnt_d  = miss_inc;
            // A clear in the same cycle as an error leaves exactly that error counted.
            if (bus.clear_err) begin
              err_count_d = ERR_W'(1);
            end else if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            if (miss_inc == 4'(UNLOCK_CNT)) begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= HUNT;
      expected_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_prbs10_checker.sv
// Scoreboard bench for prbs10_checker: a 16-bit and a 4-bit error-counter
// instance share one stimulus stream; expectations come from a table-driven model.
module tb_prbs10_checker;
  localparam int unsigned STEP = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prbs10_if #(.ERR_W(16)) b16 ();
  prbs10_if #(.ERR_W(4))  b4 ();

  prbs10_checker #(.STEP(STEP), .LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .bus(b16)
  );
  prbs10_checker #(.STEP(STEP), .LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .bus(b4)
  );

  typedef struct packed {
    logic        l;
    logic        p;
    logic [15:0] c;
    logic [1:0]  s;
    logic [3:0]  c4;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural reference: one-shift successor table plus a plain mode tracker.
  int         nxt [1024];
  int         mode;       // 0 hunting, 1 confirming, 2 locked
  int         pred;
  int         good, bad;
  int         cnt16, cnt4;
  bit         pulse;
  logic [9:0] src;

  function automatic int adv_m(input int x);
    int y = x;
    repeat (STEP) y = nxt[y];
    return y;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0; pred = 0; good = 0; bad = 0; cnt16 = 0; cnt4 = 0; pulse = 0;
  endtask

  task automatic model_update(input bit v, input int w, input bit clr);
    pulse = 0;
    if (clr) begin cnt16 = 0; cnt4 = 0; end
    if (v) begin
      if (mode == 0) begin
        if (w != 1023) begin pred = adv_m(w); good = 0; mode = 1; end
      end else if (mode == 1) begin
        if (w == pred) begin
          pred = adv_m(pred);
          good++;
          if (good == 4) begin mode = 2; bad = 0; end
        end else if (w == 1023) begin
          mode = 0; good = 0;
        end else begin
          pred = adv_m(w); good = 0;
        end
      end else begin
        if (w == pred) bad = 0;
        else begin
          pulse = 1;
          cnt16 = (cnt16 == 65535) ? 65535 : cnt16 + 1;
          cnt4  = (cnt4 == 15) ? 15 : cnt4 + 1;
          bad++;
          if (bad == 3) mode = 0;
        end
        pred = adv_m(pred);
      end
    end
  endtask

  task automatic step(input bit v, input logic [9:0] w, input bit clr, input bit r);
    exp_t e;
    @(negedge clk);
    rst           = r;
    b16.in_valid  = v;  b4.in_valid  = v;
    b16.in_word   = w;  b4.in_word   = w;
    b16.clear_err = clr; b4.clear_err = clr;
    if (r) begin
      #1;
      chk("async_rst_locked", b16.locked, 0);
      chk("async_rst_pulse", b16.err_pulse, 0);
      chk("async_rst_count", b16.err_count, 0);
      chk("async_rst_state", b16.state, 0);
      chk("async_rst_count4", b4.err_count, 0);
      model_reset();
    end else begin
      model_update(v, int'(w), clr);
    end
    e.l = (mode == 2); e.p = pulse; e.c = 16'(cnt16); e.s = 2'(mode); e.c4 = 4'(cnt4);
    q.push_back(e);
  endtask

  task automatic send_good();
    step(1'b1, src, 1'b0, 1'b0);
    src = 10'(adv_m(int'(src)));
  endtask

  task automatic send_bad(input logic [9:0] m, input bit clr);
    step(1'b1, src ^ m, clr, 1'b0);
    src = 10'(adv_m(int'(src)));
  endtask

  task automatic new_seed();
    src = 10'($urandom_range(0, 1022));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("locked", b16.locked, e.l);
        chk("err_pulse", b16.err_pulse, e.p);
        chk("err_count", b16.err_count, e.c);
        chk("state", b16.state, e.s);
        chk("locked4", b4.locked, e.l);
        chk("err_count4", b4.err_count, e.c4);
      end
    end
  end

  initial begin : stim
    int r;
    for (int i = 0; i < 1024; i++)
      nxt[i] = (i * 2) % 1024 + 1 -
               ((((i >> 9) & 1) + ((i >> 6) & 1) + ((i >> 2) & 1) + ((i >> 1) & 1)) % 2);
    b16.in_valid = 0; b16.in_word = 0; b16.clear_err = 0;
    b4.in_valid  = 0; b4.in_word  = 0; b4.clear_err  = 0;
    model_reset();

    step(1'b0, 10'h0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 10'($urandom), 1'b0, 1'b0);

    // Known seed, 100 correct words with random idle gaps.
    src = 10'h3E7;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 10'($urandom), 1'b0, 1'b0);
      send_good();
    end

    // Single-bit corruption while locked, then recovery.
    send_bad(10'h001, 1'b0);
    repeat (5) send_good();

    // Three consecutive corruptions drop lock; stream then relocks.
    repeat (3) send_bad(10'($urandom_range(1, 1023)), 1'b0);
    repeat (7) send_good();

    // Lockup word never seeds; lockup word in confirm returns to hunt.
    step(1'b0, 10'h0, 1'b0, 1'b1);
    repeat (10) step(1'b1, 10'h3FF, 1'b0, 1'b0);
    step(1'b1, 10'h3E7, 1'b0, 1'b0);
    step(1'b1, 10'h3FF, 1'b0, 1'b0);
    new_seed();
    repeat (6) send_good();

    // Alternating bad/good saturates the 4-bit counter without losing lock.
    for (int i = 0; i < 20; i++) begin
      send_bad(10'($urandom_range(1, 1023)), 1'b0);
      send_good();
    end
    send_bad(10'h200, 1'b1);
    send_good();
    step(1'b0, 10'h0, 1'b1, 1'b0);

    // Randomised mix, including mid-stream resets.
    new_seed();
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15)      step(1'b0, 10'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      else if (r < 27) send_bad(10'($urandom_range(1, 1023)), 1'($urandom_range(0, 7) == 0));
      else if (r < 29) step(1'b1, 10'h3FF, 1'b0, 1'b0);
      else if (r < 30) begin
        step(1'b1, src, 1'b0, 1'b1);
        new_seed();
      end
      else if (r < 32) new_seed();
      else             send_good();
    end

    repeat (3) step(1'b0, 10'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prbs10_checker.md
# prbs10_checker

Receive-side checker for the 10-bit XNOR LFSR word stream (polynomial x^10+x^7+x^3+x^2+1, XNOR feedback, one word per 11 shifts). It self-synchronises on incoming words and predicts each next word by advancing its own LFSR copy STEP shifts. It then declares lock, counts word errors once locked, and drops lock after sustained mismatch. It sits at the far end of a link or loopback path fed by the team's LFSR word source and is the pass/fail element for random-stream integrity tests.

## Interface
- STEP, 11: LFSR shifts between consecutive words (1..15).
- LOCK_CNT, 4: consecutive correct predictions required to declare lock (1..15).
- UNLOCK_CNT, 3: consecutive mispredictions while locked that drop lock (1..15).
- ERR_W, 16: error counter width.

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  in_word is presented this cycle; no backpressure, any gap length allowed
- in_word  in  10  received word
- clear_err  in  1  synchronous clear of err_count
- locked  out  1  checker is in LOCKED
- err_pulse  out  1  one-cycle flag: the word accepted last cycle mismatched while locked
- err_count  out  ERR_W  saturating count of mismatched words while locked
- state  out  2  debug: 0 HUNT, 1 CONFIRM, 2 LOCKED

## Operation
- adv(x) means STEP iterations of x <= {x[8:0], ~(x[9]^x[6]^x[2]^x[1])}. It is combinational over STEP unrolled stages, with no multicycle path. 0x3FF is the lockup state: adv(0x3FF) = 0x3FF.
- Registers: expected[9:0], match_cnt[3:0], miss_cnt[3:0], FSM state, err_count, err_pulse.
- Nothing changes on cycles with in_valid=0, except the clear_err effect and err_pulse returning to 0.
- HUNT (reset state), on in_valid:
  - If in_word = 0x3FF, stay in HUNT; it is never used as a seed.
  - Otherwise set expected <= adv(in_word), match_cnt <= 0, and go to CONFIRM.
- CONFIRM, on in_valid:
  - Match (in_word == expected): expected <= adv(expected) and match_cnt++. When the incremented value equals LOCK_CNT, go to LOCKED with miss_cnt <= 0.
  - Mismatch: reseed with expected <= adv(in_word) and match_cnt <= 0, staying in CONFIRM. If in_word = 0x3FF, go to HUNT instead.
  - No error is counted in CONFIRM.
- LOCKED, on in_valid:
  - expected <= adv(expected) always (flywheel); in_word is never used to reseed.
  - Match: miss_cnt <= 0.
  - Mismatch: err_pulse <= 1, err_count increments (saturates at all-ones), and miss_cnt++. When the incremented value equals UNLOCK_CNT, go to HUNT.
- clear_err combined with an error in the same cycle gives err_count = 1. clear_err alone gives 0. clear_err has no effect on the FSM.
- A word is a mismatch if any of its 10 bits differs. Bit-error counting is out of scope.

## Timing
- Reset values: locked=0, err_pulse=0, err_count=0, state=HUNT (0), expected=0, match_cnt=0, miss_cnt=0.
- All outputs are registered. Every response appears on the clock edge that samples in_valid=1, and is visible the following cycle.
- Lock latency: seed word plus LOCK_CNT matching words. locked rises after the edge that samples the LOCK_CNT-th match; with defaults, after the 5th accepted word.
- err_pulse is high for exactly one cycle per mismatched word. Back-to-back mismatched words on consecutive cycles give a continuous high.
- Unlock: locked falls after the edge sampling the UNLOCK_CNT-th consecutive mismatch, and that word is still counted as an error.
- Reset asserted mid-stream forces the reset values immediately, asynchronously. After release, the first accepted word is a new HUNT seed.
- in_valid may be asserted every cycle. There is no requirement on word spacing.

## Test plan
- Reset then idle: locked=0, err_count=0, err_pulse=0, state=0 for 20 cycles, including with in_valid=0 and random in_word.
- Seed 0x3E7, then feed the correct successors adv(0x3E7)=0x20E and onward: state goes 0→1, locked=1 after the 4th match, err_count stays 0 over 100 words.
- While locked, replace one word with that word ^ 0x001: err_pulse high exactly 1 cycle, err_count=1, locked stays 1, and the next correct word matches with no second pulse.
- While locked, send 3 consecutive corrupted words: err_count=3, locked falls after the 3rd, state=HUNT. Re-seeding then needs 5 words to relock.
- Send 0x3FF repeatedly in HUNT: state stays 0 and locked never rises. Seed 0x3E7 then send 0x3FF in CONFIRM: returns to HUNT.
- ERR_W=4, locked, alternating bad/good words 20 times: err_count saturates at 15 and lock is held. clear_err with a simultaneous bad word gives 1. Reset asserted mid-sequence clears all outputs within the cycle.
